// File: rtl/hazard_unit.sv
// ============================================================================
// hazard_unit : stall/flush/forwarding control for the 5-stage MIPS pipeline
// Rev 1.0
// ============================================================================
`default_nettype none

module hazard_unit #(
  parameter int TIMEOUT = 16,
  parameter int CNTW    = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      rsd,
  input  logic [4:0]      rtd,
  input  logic [4:0]      rse,
  input  logic [4:0]      rte,
  input  logic [4:0]      writerege,
  input  logic [4:0]      writeregm,
  input  logic [4:0]      writeregw,
  input  logic            regwritee,
  input  logic            regwritem,
  input  logic            regwritew,
  input  logic            memtorege,
  input  logic            memtoregm,
  input  logic            branchd,
  input  logic            memreqm,
  input  logic            memreadym,
  input  logic            clrcnt,
  output logic            stallf,
  output logic            stalld,
  output logic            stalle,
  output logic            stallm,
  output logic            flushe,
  output logic            flushw,
  output logic            forwardad,
  output logic            forwardbd,
  output logic [1:0]      forwardae,
  output logic [1:0]      forwardbe,
  output logic            memerr,
  output logic [CNTW-1:0] stallcnt,
  output logic [CNTW-1:0] flushcnt
);

  localparam int WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MEMWAIT = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [WCW-1:0]  waitcnt_q, waitcnt_d;
  logic            memerr_q, memerr_d;
  logic [CNTW-1:0] stallcnt_q, stallcnt_d;
  logic [CNTW-1:0] flushcnt_q, flushcnt_d;

  logic [1:0] fwd_ae, fwd_be;
  logic       fwd_ad, fwd_bd;
  logic       lwstall, branchstall, memstall, timeout_now;
  logic       hit_e, hit_m;

  always_comb begin : fwd_comb
    fwd_ae = 2'b00;
    if (rse != 5'd0 && rse == writeregm && regwritem)      fwd_ae = 2'b10;
    else if (rse != 5'd0 && rse == writeregw && regwritew) fwd_ae = 2'b01;

    fwd_be = 2'b00;
    if (rte != 5'd0 && rte == writeregm && regwritem)      fwd_be = 2'b10;
    else if (rte != 5'd0 && rte == writeregw && regwritew) fwd_be = 2'b01;

    fwd_ad = (rsd != 5'd0) && (rsd == writeregm) && regwritem;
    fwd_bd = (rtd != 5'd0) && (rtd == writeregm) && regwritem;
  end

  always_comb begin : hazard_comb
    lwstall = memtorege && (rte != 5'd0) && ((rsd == rte) || (rtd == rte));

    hit_e = regwritee && (writerege != 5'd0) &&
            ((writerege == rsd) || (writerege == rtd));
    hit_m = memtoregm && (writeregm != 5'd0) &&
            ((writeregm == rsd) || (writeregm == rtd));
    branchstall = branchd && (hit_e || hit_m);

    // The final permitted wait cycle is released unstalled so the access
    // retires with undefined data instead of hanging the pipeline.
    timeout_now = (state_q == MEMWAIT) && (waitcnt_q == WAIT_LAST);
    memstall    = memreqm && !memreadym && !memerr_q && !timeout_now;
  end

  always_comb begin : ctl_comb
    stallf    = 1'b0;
    stalld    = 1'b0;
    stalle    = 1'b0;
    stallm    = 1'b0;
    flushe    = 1'b0;
    flushw    = 1'b0;
    forwardae = fwd_ae;
    forwardbe = fwd_be;
    forwardad = fwd_ad;
    forwardbd = fwd_bd;
    if (reset) begin
      flushe    = 1'b1;
      flushw    = 1'b1;
      forwardae = 2'b00;
      forwardbe = 2'b00;
      forwardad = 1'b0;
      forwardbd = 1'b0;
    end else if (memstall) begin
      stallf = 1'b1;
      stalld = 1'b1;
      stalle = 1'b1;
      stallm = 1'b1;
      flushw = 1'b1;
    end else if (lwstall || branchstall) begin
      stallf = 1'b1;
      stalld = 1'b1;
      flushe = 1'b1;
    end
  end

  always_comb begin : fsm_comb
    state_d   = state_q;
    waitcnt_d = waitcnt_q;
    memerr_d  = memerr_q;
    case (state_q)
      RUN: begin
        if (memstall) begin
          state_d   = MEMWAIT;
          waitcnt_d = '0;
        end
      end
      MEMWAIT: begin
        if (memreadym || !memreqm) begin
          state_d = RUN;
        end else if (timeout_now) begin
          state_d  = RUN;
          memerr_d = 1'b1;
        end else begin
          waitcnt_d = waitcnt_q + WCW'(1);
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin : cnt_comb
    stallcnt_d = stallcnt_q;
    flushcnt_d = flushcnt_q;
    if (clrcnt) begin
      stallcnt_d = '0;
      flushcnt_d = '0;
    end else begin
      if (stalld && stallcnt_q != '1) stallcnt_d = stallcnt_q + CNTW'(1);
      if (flushe && flushcnt_q != '1) flushcnt_d = flushcnt_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      waitcnt_q  <= '0;
      memerr_q   <= 1'b0;
      stallcnt_q <= '0;
      flushcnt_q <= '0;
    end else begin
      state_q    <= state_d;
      waitcnt_q  <= waitcnt_d;
      memerr_q   <= memerr_d;
      stallcnt_q <= stallcnt_d;
      flushcnt_q <= flushcnt_d;
    end
  end

  assign memerr   = memerr_q;
  assign stallcnt = stallcnt_q;
  assign flushcnt = flushcnt_q;

endmodule

`default_nettype wire

// File: tb/tb_hazard_unit.sv
// ============================================================================
// tb_hazard_unit : directed + randomized bench with a behavioural model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_hazard_unit;

  localparam int TO = 4;
  localparam int WA = 16;
  localparam int WB = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [4:0] rsd, rtd, rse, rte, writerege, writeregm, writeregw;
  logic       regwritee, regwritem, regwritew, memtorege, memtoregm;
  logic       branchd, memreqm, memreadym, clrcnt;

  logic          stallf_a, stalld_a, stalle_a, stallm_a, flushe_a, flushw_a;
  logic          forwardad_a, forwardbd_a, memerr_a;
  logic [1:0]    forwardae_a, forwardbe_a;
  logic [WA-1:0] stallcnt_a, flushcnt_a;

  logic          stallf_b, stalld_b, stalle_b, stallm_b, flushe_b, flushw_b;
  logic          forwardad_b, forwardbd_b, memerr_b;
  logic [1:0]    forwardae_b, forwardbe_b;
  logic [WB-1:0] stallcnt_b, flushcnt_b;

  hazard_unit #(.TIMEOUT(TO), .CNTW(WA)) dut_a (
    .clk(clk), .reset(reset), .rsd(rsd), .rtd(rtd), .rse(rse), .rte(rte),
    .writerege(writerege), .writeregm(writeregm), .writeregw(writeregw),
    .regwritee(regwritee), .regwritem(regwritem), .regwritew(regwritew),
    .memtorege(memtorege), .memtoregm(memtoregm), .branchd(branchd),
    .memreqm(memreqm), .memreadym(memreadym), .clrcnt(clrcnt),
    .stallf(stallf_a), .stalld(stalld_a), .stalle(stalle_a), .stallm(stallm_a),
    .flushe(flushe_a), .flushw(flushw_a), .forwardad(forwardad_a),
    .forwardbd(forwardbd_a), .forwardae(forwardae_a), .forwardbe(forwardbe_a),
    .memerr(memerr_a), .stallcnt(stallcnt_a), .flushcnt(flushcnt_a)
  );

  hazard_unit #(.TIMEOUT(TO), .CNTW(WB)) dut_b (
    .clk(clk), .reset(reset), .rsd(rsd), .rtd(rtd), .rse(rse), .rte(rte),
    .writerege(writerege), .writeregm(writeregm), .writeregw(writeregw),
    .regwritee(regwritee), .regwritem(regwritem), .regwritew(regwritew),
    .memtorege(memtorege), .memtoregm(memtoregm), .branchd(branchd),
    .memreqm(memreqm), .memreadym(memreadym), .clrcnt(clrcnt),
    .stallf(stallf_b), .stalld(stalld_b), .stalle(stalle_b), .stallm(stallm_b),
    .flushe(flushe_b), .flushw(flushw_b), .forwardad(forwardad_b),
    .forwardbd(forwardbd_b), .forwardae(forwardae_b), .forwardbe(forwardbe_b),
    .memerr(memerr_b), .stallcnt(stallcnt_b), .flushcnt(flushcnt_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model state: length of the current unbroken memory wait, sticky error,
  // and unbounded event counts clamped to each instance's width.
  int m_wait, m_scnt_a, m_fcnt_a, m_scnt_b, m_fcnt_b;
  bit m_err;

  function automatic logic [1:0] fwd_e(input logic [4:0] r);
    if (r != 0 && r == writeregm && regwritem) return 2'b10;
    if (r != 0 && r == writeregw && regwritew) return 2'b01;
    return 2'b00;
  endfunction

  function automatic int sat_inc(input int v, input int w);
    return (v >= (1 << w) - 1) ? v : v + 1;
  endfunction

  task automatic clear_inputs();
    {rsd, rtd, rse, rte, writerege, writeregm, writeregw} = '0;
    {regwritee, regwritem, regwritew, memtorege, memtoregm} = '0;
    {branchd, memreqm, memreadym, clrcnt} = '0;
  endtask

  // Called just after a negedge with inputs applied; checks, then advances.
  task automatic cycle();
    logic lw, br, mem, e_stalld, e_flushe;
    logic [5:0] e_ctl, e_fwd;
    #1;
    lw  = memtorege && rte != 0 && (rsd == rte || rtd == rte);
    br  = branchd && ((regwritee && writerege != 0 && (writerege == rsd || writerege == rtd)) ||
                      (memtoregm && writeregm != 0 && (writeregm == rsd || writeregm == rtd)));
    mem = memreqm && !memreadym && !m_err && (m_wait < TO);
    if (reset) begin
      e_ctl = 6'b000011;
      e_fwd = 6'b0;
    end else begin
      if (mem)            e_ctl = 6'b111101;
      else if (lw || br)  e_ctl = 6'b110010;
      else                e_ctl = 6'b000000;
      e_fwd = {rsd != 0 && rsd == writeregm && regwritem,
               rtd != 0 && rtd == writeregm && regwritem,
               fwd_e(rse), fwd_e(rte)};
    end
    e_stalld = e_ctl[4];
    e_flushe = e_ctl[1];

    check("ctl_a", 32'({stallf_a, stalld_a, stalle_a, stallm_a, flushe_a, flushw_a}), 32'(e_ctl));
    check("fwd_a", 32'({forwardad_a, forwardbd_a, forwardae_a, forwardbe_a}), 32'(e_fwd));
    check("memerr_a", 32'(memerr_a), 32'(m_err));
    check("stallcnt_a", 32'(stallcnt_a), 32'(m_scnt_a));
    check("flushcnt_a", 32'(flushcnt_a), 32'(m_fcnt_a));
    check("ctl_b", 32'({stallf_b, stalld_b, stalle_b, stallm_b, flushe_b, flushw_b}), 32'(e_ctl));
    check("fwd_b", 32'({forwardad_b, forwardbd_b, forwardae_b, forwardbe_b}), 32'(e_fwd));
    check("memerr_b", 32'(memerr_b), 32'(m_err));
    check("stallcnt_b", 32'(stallcnt_b), 32'(m_scnt_b));
    check("flushcnt_b", 32'(flushcnt_b), 32'(m_fcnt_b));

    @(posedge clk);
    if (reset) begin
      m_wait = 0; m_err = 0;
      m_scnt_a = 0; m_fcnt_a = 0; m_scnt_b = 0; m_fcnt_b = 0;
    end else begin
      if (mem) m_wait++;
      else begin
        if (memreqm && !memreadym && !m_err && m_wait == TO) m_err = 1;
        m_wait = 0;
      end
      if (clrcnt) begin
        m_scnt_a = 0; m_fcnt_a = 0; m_scnt_b = 0; m_fcnt_b = 0;
      end else begin
        if (e_stalld) begin m_scnt_a = sat_inc(m_scnt_a, WA); m_scnt_b = sat_inc(m_scnt_b, WB); end
        if (e_flushe) begin m_fcnt_a = sat_inc(m_fcnt_a, WA); m_fcnt_b = sat_inc(m_fcnt_b, WB); end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    m_wait = 0; m_err = 0;
    m_scnt_a = 0; m_fcnt_a = 0; m_scnt_b = 0; m_fcnt_b = 0;
    clear_inputs();
    reset = 1'b1;
    @(negedge clk);
    cycle();
    cycle();
    reset = 1'b0;

    // Forwarding priority
    rse = 5'd5; writeregm = 5'd5; regwritem = 1; writeregw = 5'd5; regwritew = 1;
    #1 check("fwd_prio_m", 32'(forwardae_a), 32'd2);
    cycle();
    regwritem = 0;
    #1 check("fwd_prio_w", 32'(forwardae_a), 32'd1);
    cycle();
    rse = 5'd0;
    #1 check("fwd_prio_r0", 32'(forwardae_a), 32'd0);
    cycle();

    // Load-use
    clear_inputs(); clrcnt = 1; cycle(); clrcnt = 0;
    memtorege = 1; rte = 5'd8; rsd = 5'd8;
    #1 check("lu_ctl", 32'({stallf_a, stalld_a, stalle_a, flushe_a}), 32'b1101);
    cycle();
    check("lu_cnt", 32'({stallcnt_a, flushcnt_a}), {16'd1, 16'd1});
    memtorege = 0;
    #1 check("lu_clear", 32'({stallf_a, stalld_a, flushe_a}), 32'b000);
    cycle();

    // Branch hazards
    clear_inputs();
    branchd = 1; rsd = 5'd3; regwritee = 1; writerege = 5'd3;
    #1 check("br_e", 32'({stalld_a, flushe_a}), 32'b11);
    cycle();
    memtoregm = 1; writeregm = 5'd3; regwritee = 0;
    #1 check("br_m_load", 32'(stalld_a), 32'd1);
    cycle();
    regwritem = 1; memtoregm = 0;
    #1 check("br_m_alu", 32'({forwardad_a, stalld_a}), 32'b10);
    cycle();

    // Memory wait of 4 cycles
    clear_inputs(); clrcnt = 1; cycle(); clrcnt = 0;
    memreqm = 1;
    for (int i = 0; i < 3; i++) begin
      #1 check("mw_stall", 32'({stallf_a, stalld_a, stalle_a, stallm_a, flushw_a, flushe_a}), 32'b111110);
      cycle();
    end
    memreadym = 1;
    #1 check("mw_release", 32'({stallm_a, flushw_a}), 32'b00);
    cycle();
    clear_inputs();
    check("mw_cnt", 32'({stallcnt_a, 15'd0, memerr_a}), {16'd3, 16'd0});
    cycle();

    // Timeout
    memreqm = 1;
    for (int i = 0; i < TO; i++) begin
      #1 check("to_stall", 32'(stallm_a), 32'd1);
      cycle();
    end
    #1 check("to_release", 32'({stallf_a, stallm_a}), 32'b00);
    cycle();
    check("to_memerr", 32'(memerr_a), 32'd1);
    #1 check("to_nostall", 32'(stallm_a), 32'd0);
    cycle();

    // Reset mid-MEMWAIT
    reset = 1; clear_inputs(); cycle(); reset = 0;
    memreqm = 1; cycle(); cycle();
    reset = 1;
    #1 check("rst_force", 32'({stallf_a, flushe_a, flushw_a}), 32'b011);
    cycle();
    reset = 0;
    check("rst_state", 32'({stallcnt_a, 15'd0, memerr_a}), 32'd0);
    cycle(); cycle();
    memreqm = 0; cycle();

    // Saturation and clear-vs-event
    clear_inputs(); clrcnt = 1; cycle(); clrcnt = 0;
    memtorege = 1; rte = 5'd7; rtd = 5'd7;
    repeat (5) cycle();
    check("sat_b", 32'(stallcnt_b), 32'd3);
    check("nosat_a", 32'(stallcnt_a), 32'd5);
    clrcnt = 1; cycle(); clrcnt = 0;
    check("clr_event", 32'({stallcnt_a, 14'd0, stallcnt_b}), 32'd0);
    clear_inputs(); cycle();

    // Randomized
    for (int n = 0; n < 3000; n++) begin
      reset     = ($urandom_range(99) == 0);
      clrcnt    = ($urandom_range(49) == 0);
      rsd       = 5'($urandom_range(3));
      rtd       = 5'($urandom_range(3));
      rse       = 5'($urandom_range(3));
      rte       = 5'($urandom_range(3));
      writerege = 5'($urandom_range(3));
      writeregm = 5'($urandom_range(3));
      writeregw = 5'($urandom_range(3));
      regwritee = 1'($urandom_range(1));
      regwritem = 1'($urandom_range(1));
      regwritew = 1'($urandom_range(1));
      memtorege = 1'($urandom_range(1));
      memtoregm = 1'($urandom_range(1));
      branchd   = 1'($urandom_range(1));
      memreqm   = 1'($urandom_range(1));
      memreadym = ($urandom_range(3) == 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
